scheduler3_allocate_rsv_station: RTL and testbench

Parametrised dispatch allocator for the scheduler: maps the two decoded orders per cycle onto the branch (RS0), load/store (RS3) and P_ALU_NUM ALU reservation stations. Unlike the fixed two-ALU version, it keeps its own per-ALU occupancy counters. Pipe 1's choice accounts for pipe 0's same-cycle allocation, ties break round-robin, and the pair stalls atomically when an ALU order cannot be placed. It sits between the decoder output register and the reservation-station write ports.

---
 rtl/scheduler3_allocate_rsv_station_if.sv | 29 ++
 rtl/scheduler3_allocate_rsv_station.sv | 121 ++++++++++++
 tb/tb_scheduler3_allocate_rsv_station.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/scheduler3_allocate_rsv_station_if.sv
// Dispatch-allocator bus: decoded order pair in, reservation-station write selects,
// stall and ALU occupancy out.
interface scheduler3_allocate_rsv_station_if #(
  parameter int unsigned P_ALU_NUM = 2,
  parameter int unsigned P_CNT_W   = 4
);
  logic                           iORDER_LOCK;
  logic                           iORDER_0_VALID;
  logic                           iORDER_1_VALID;
  logic [9:0]                     iORDER_0_EX;
  logic [9:0]                     iORDER_1_EX;
  logic [P_ALU_NUM-1:0]           iALU_RELEASE;
  logic [1:0]                     oRS0_VALID;
  logic [1:0]                     oRS3_VALID;
  logic [P_ALU_NUM-1:0]           oALU_0_VALID;
  logic [P_ALU_NUM-1:0]           oALU_1_VALID;
  logic                           oALLOC_STALL;
  logic [P_ALU_NUM*P_CNT_W-1:0]   oALU_COUNT;

  modport master (
    output iORDER_LOCK, iORDER_0_VALID, iORDER_1_VALID, iORDER_0_EX, iORDER_1_EX, iALU_RELEASE,
    input  oRS0_VALID, oRS3_VALID, oALU_0_VALID, oALU_1_VALID, oALLOC_STALL, oALU_COUNT
  );

  modport slave (
    input  iORDER_LOCK, iORDER_0_VALID, iORDER_1_VALID, iORDER_0_EX, iORDER_1_EX, iALU_RELEASE,
    output oRS0_VALID, oRS3_VALID, oALU_0_VALID, oALU_1_VALID, oALLOC_STALL, oALU_COUNT
  );
endinterface

// File: rtl/scheduler3_allocate_rsv_station.sv
// Two-wide dispatch allocator onto branch, load/store and P_ALU_NUM ALU reservation
// stations, with per-ALU occupancy counters and round-robin tie breaking.
module scheduler3_allocate_rsv_station #(
  parameter int unsigned P_ALU_NUM  = 2,
  parameter int unsigned P_RS_DEPTH = 8,
  parameter int unsigned P_CNT_W    = 4
) (
  input  logic iCLOCK,
  input  logic iRESET,
  input  logic iRESET_SYNC,
  scheduler3_allocate_rsv_station_if.slave bus
);
  localparam int unsigned RR_W  = $clog2(P_ALU_NUM);
  localparam int unsigned SUM_W = P_CNT_W + 1;

  logic [P_ALU_NUM-1:0][P_CNT_W-1:0] r_cnt;
  logic [P_ALU_NUM-1:0][P_CNT_W-1:0] w_cnt_next;
  logic [RR_W-1:0]                   r_rr;
  logic [RR_W-1:0]                   w_rr_next;

  logic             w_need0, w_need1, w_only0, w_only1;
  logic             w_found0, w_found1, w_use0;
  logic [RR_W-1:0]  w_pick0, w_pick1;
  logic             w_stall, w_en, w_alloc0, w_alloc1;
  logic [P_ALU_NUM-1:0] w_sel0, w_sel1;

  // Least-occupied eligible non-full ALU; ties go to the first index scanning from start.
  function automatic logic [RR_W:0] f_pick(
    input logic [P_ALU_NUM-1:0][P_CNT_W-1:0] cnt,
    input logic [P_ALU_NUM-1:0]              elig,
    input logic [P_ALU_NUM-1:0]              bump,
    input int unsigned                       start
  );
    logic             found;
    logic [RR_W-1:0]  pick;
    logic [SUM_W-1:0] eff, best;
    int unsigned      rank, best_rank;
    found     = 1'b0;
    pick      = '0;
    best      = '0;
    best_rank = 0;
    for (int unsigned k = 0; k < P_ALU_NUM; k++) begin
      eff  = {1'b0, cnt[k]} + SUM_W'(bump[k]);
      rank = (k + P_ALU_NUM - start) % P_ALU_NUM;
      if (elig[k] && (eff < SUM_W'(P_RS_DEPTH)) &&
          (!found || (eff < best) || ((eff == best) && (rank < best_rank)))) begin
        found     = 1'b1;
        pick      = RR_W'(k);
        best      = eff;
        best_rank = rank;
      end
    end
    return {found, pick};
  endfunction

  always_comb begin
    w_need0 = |{bus.iORDER_0_EX[7:2], bus.iORDER_0_EX[0]};
    w_need1 = |{bus.iORDER_1_EX[7:2], bus.iORDER_1_EX[0]};
    w_only0 = |bus.iORDER_0_EX[7:5];
    w_only1 = |bus.iORDER_1_EX[7:5];

    {w_found0, w_pick0} = f_pick(r_cnt, w_only0 ? P_ALU_NUM'(1) : '1, '0, 32'(r_rr));
    w_use0 = bus.iORDER_0_VALID && w_need0 && w_found0;
    // Pipe 1 sees pipe 0's same-cycle allocation as one extra entry.
    {w_found1, w_pick1} = f_pick(r_cnt, w_only1 ? P_ALU_NUM'(1) : '1,
                                 w_use0 ? (P_ALU_NUM'(1) << w_pick0) : '0,
                                 w_use0 ? (32'(w_pick0) + 1) % P_ALU_NUM : 32'(r_rr));

    w_stall  = !bus.iORDER_LOCK && !iRESET_SYNC &&
               ((bus.iORDER_0_VALID && w_need0 && !w_found0) ||
                (bus.iORDER_1_VALID && w_need1 && !w_found1));
    w_en     = !bus.iORDER_LOCK && !iRESET_SYNC && !w_stall;
    w_alloc0 = w_en && bus.iORDER_0_VALID && w_need0;
    w_alloc1 = w_en && bus.iORDER_1_VALID && w_need1;
    w_sel0   = w_alloc0 ? (P_ALU_NUM'(1) << w_pick0) : '0;
    w_sel1   = w_alloc1 ? (P_ALU_NUM'(1) << w_pick1) : '0;

    bus.oALU_0_VALID = w_sel0;
    bus.oALU_1_VALID = w_sel1;
    bus.oALLOC_STALL = w_stall;
    bus.oRS0_VALID   = {w_en && bus.iORDER_1_VALID && bus.iORDER_1_EX[9],
                        w_en && bus.iORDER_0_VALID && bus.iORDER_0_EX[9]};
    bus.oRS3_VALID   = {w_en && bus.iORDER_1_VALID && (bus.iORDER_1_EX[8] || bus.iORDER_1_EX[1]),
                        w_en && bus.iORDER_0_VALID && (bus.iORDER_0_EX[8] || bus.iORDER_0_EX[1])};
    bus.oALU_COUNT   = r_cnt;
  end

  // Occupancy next state: allocs add, a release only subtracts from a non-empty total.
  always_comb begin
    logic [SUM_W-1:0] v_sum;
    w_cnt_next = r_cnt;
    v_sum      = '0;
    for (int unsigned k = 0; k < P_ALU_NUM; k++) begin
      v_sum = {1'b0, r_cnt[k]} + SUM_W'(w_sel0[k]) + SUM_W'(w_sel1[k]);
      if (bus.iALU_RELEASE[k] && (v_sum != '0)) v_sum = v_sum - SUM_W'(1);
      w_cnt_next[k] = P_CNT_W'(v_sum);
    end
    if (w_alloc1)      w_rr_next = RR_W'((32'(w_pick1) + 1) % P_ALU_NUM);
    else if (w_alloc0) w_rr_next = RR_W'((32'(w_pick0) + 1) % P_ALU_NUM);
    else               w_rr_next = r_rr;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_cnt <= '0;
      r_rr  <= '0;
    end else if (iRESET_SYNC) begin
      r_cnt <= '0;
      r_rr  <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_rr  <= w_rr_next;
    end
  end

  always_ff @(posedge iCLOCK) begin
    assert ($onehot0(w_sel0));
    assert ($onehot0(w_sel1));
    for (int unsigned k = 0; k < P_ALU_NUM; k++) assert (SUM_W'(r_cnt[k]) <= SUM_W'(P_RS_DEPTH));
  end
endmodule

// File: tb/tb_scheduler3_allocate_rsv_station.sv
// Directed bench: three ALU stations of depth 4, hand-computed selects and occupancies.
module tb_scheduler3_allocate_rsv_station;
  localparam int unsigned N  = 3;
  localparam int unsigned CW = 3;

  localparam logic [9:0] NONE  = 10'b00_0000_0000;
  localparam logic [9:0] SYSL  = 10'b00_0000_0010;
  localparam logic [9:0] LOGIC = 10'b00_0000_0100;
  localparam logic [9:0] SHIFT = 10'b00_0000_1000;
  localparam logic [9:0] ADDER = 10'b00_0001_0000;
  localparam logic [9:0] MUL   = 10'b00_0010_0000;
  localparam logic [9:0] LDST  = 10'b01_0000_0000;
  localparam logic [9:0] BRNCH = 10'b10_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_sync = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  scheduler3_allocate_rsv_station_if #(.P_ALU_NUM(N), .P_CNT_W(CW)) bus ();

  scheduler3_allocate_rsv_station #(.P_ALU_NUM(N), .P_RS_DEPTH(4), .P_CNT_W(CW)) dut (
    .iCLOCK      (clk),
    .iRESET      (rst),
    .iRESET_SYNC (rst_sync),
    .bus         (bus)
  );

  task automatic drive(input logic v0, input logic [9:0] e0, input logic v1, input logic [9:0] e1,
                       input logic [2:0] rel, input logic lock, input logic sync);
    bus.iORDER_0_VALID = v0;
    bus.iORDER_0_EX    = e0;
    bus.iORDER_1_VALID = v1;
    bus.iORDER_1_EX    = e1;
    bus.iALU_RELEASE   = rel;
    bus.iORDER_LOCK    = lock;
    rst_sync           = sync;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs packed as {alu1, alu0, rs0, rs3, stall}.
  task automatic chk_out(input string tag, input logic [2:0] a0, input logic [2:0] a1,
                         input logic [1:0] rs0, input logic [1:0] rs3, input logic stall);
    logic [10:0] obs, exp;
    obs = {bus.oALU_1_VALID, bus.oALU_0_VALID, bus.oRS0_VALID, bus.oRS3_VALID, bus.oALLOC_STALL};
    exp = {a1, a0, rs0, rs3, stall};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int c0, input int c1, input int c2);
    logic [8:0] exp;
    exp = {CW'(c2), CW'(c1), CW'(c0)};
    n_cmp++;
    assert (bus.oALU_COUNT === exp) else begin
      n_err++;
      $error("FAIL %s: observed counts %h expected %h", tag, bus.oALU_COUNT, exp);
    end
  endtask

  initial begin
    drive(0, NONE, 0, NONE, 3'b000, 0, 0);
    #12;
    chk_cnt("reset_cnt", 0, 0, 0);
    chk_out("reset_out", 3'b000, 3'b000, 2'b00, 2'b00, 0);
    rst = 1'b0;
    tick();

    drive(1, ADDER, 1, LOGIC, 3'b000, 0, 0);
    chk_out("first_pair", 3'b001, 3'b010, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("first_pair_cnt", 1, 1, 0);

    drive(1, LDST, 1, SYSL, 3'b000, 0, 0);
    chk_out("ldst_pair", 3'b000, 3'b000, 2'b00, 2'b11, 0);
    tick();
    drive(1, NONE, 1, BRNCH, 3'b000, 0, 0);
    chk_out("noclass_branch", 3'b000, 3'b000, 2'b10, 2'b00, 0);
    tick();
    chk_cnt("non_alu_cnt", 1, 1, 0);

    drive(1, ADDER, 1, ADDER, 3'b011, 1, 0);
    chk_out("lock_out", 3'b000, 3'b000, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("lock_release", 0, 0, 0);

    drive(1, ADDER, 1, ADDER, 3'b000, 0, 1);
    chk_out("sync_clear_out", 3'b000, 3'b000, 2'b00, 2'b00, 0);
    tick();

    drive(1, MUL, 1, MUL, 3'b000, 0, 0);
    chk_out("mul_mul", 3'b001, 3'b001, 2'b00, 2'b00, 0);
    tick();
    drive(1, ADDER, 1, ADDER, 3'b000, 0, 0);
    chk_out("rr_from1", 3'b010, 3'b100, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("cnt_211", 2, 1, 1);

    drive(1, ADDER, 1, ADDER, 3'b000, 0, 0);
    chk_out("min_pick", 3'b010, 3'b100, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("cnt_222", 2, 2, 2);

    drive(1, MUL, 1, MUL, 3'b000, 0, 0);
    tick();
    drive(1, ADDER, 1, ADDER, 3'b000, 0, 0);
    chk_out("skip_full0", 3'b010, 3'b100, 2'b00, 2'b00, 0);
    tick();
    drive(1, ADDER, 1, ADDER, 3'b000, 0, 0);
    tick();
    chk_cnt("cnt_444", 4, 4, 4);

    drive(0, NONE, 0, NONE, 3'b001, 1, 0);
    tick();
    drive(1, SHIFT, 1, SHIFT, 3'b000, 0, 0);
    chk_out("pipe1_unplaceable", 3'b000, 3'b000, 2'b00, 2'b00, 1);
    tick();
    chk_cnt("stall_hold", 3, 4, 4);

    for (int i = 0; i < 4; i++) begin
      drive(0, NONE, 0, NONE, 3'b110, 1, 0);
      tick();
    end
    chk_cnt("drain12", 3, 0, 0);
    drive(1, MUL, 0, NONE, 3'b000, 0, 0);
    tick();
    drive(1, MUL, 1, BRNCH, 3'b001, 0, 0);
    chk_out("mul_full_stall", 3'b000, 3'b000, 2'b00, 2'b00, 1);
    tick();
    chk_cnt("stall_release", 3, 0, 0);
    drive(1, MUL, 1, BRNCH, 3'b000, 0, 0);
    chk_out("mul_retry", 3'b001, 3'b000, 2'b10, 2'b00, 0);
    tick();
    chk_cnt("mul_retry_cnt", 4, 0, 0);

    for (int i = 0; i < 3; i++) begin
      drive(0, NONE, 0, NONE, 3'b001, 1, 0);
      tick();
    end
    drive(1, MUL, 0, NONE, 3'b001, 0, 0);
    chk_out("alloc_rel_out", 3'b001, 3'b000, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("alloc_plus_release", 1, 0, 0);
    drive(0, NONE, 0, NONE, 3'b010, 1, 0);
    tick();
    chk_cnt("release_empty", 1, 0, 0);

    drive(1, MUL, 1, MUL, 3'b000, 0, 0);
    tick();
    drive(1, ADDER, 1, ADDER, 3'b000, 0, 0);
    tick();
    drive(1, ADDER, 0, NONE, 3'b000, 0, 0);
    chk_out("single_pipe0", 3'b010, 3'b000, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("cnt_321", 3, 2, 1);

    drive(1, ADDER, 1, BRNCH, 3'b111, 0, 1);
    chk_out("sync_out", 3'b000, 3'b000, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("sync_cnt", 0, 0, 0);
    drive(1, ADDER, 1, LOGIC, 3'b000, 0, 0);
    chk_out("sync_rr0", 3'b001, 3'b010, 2'b00, 2'b00, 0);
    tick();
    chk_cnt("post_sync_cnt", 1, 1, 0);

    drive(0, NONE, 0, NONE, 3'b000, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt("async_reset", 0, 0, 0);
    #3;
    rst = 1'b0;
    tick();
    chk_out("idle_after_reset", 3'b000, 3'b000, 2'b00, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
